// File: rtl/keypad_scan_ctrl.sv
// 4x4 key matrix scanner: one column driven at a time, one shared debounce path
// for all 16 keys, debounced press/release events queued in a show-ahead FIFO.
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [3:0] ev_code,
    output logic       ev_press,
    output logic       overflow,
    output logic       key_down
);

    localparam int unsigned SET_W = 8;
    localparam int unsigned DB_W  = 4;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] S_DRIVE   = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_PROC0   = 3'd2;
    localparam logic [2:0] S_PROC1   = 3'd3;
    localparam logic [2:0] S_PROC2   = 3'd4;
    localparam logic [2:0] S_PROC3   = 3'd5;
    localparam logic [2:0] S_NEXT    = 3'd6;

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [SET_W-1:0] r_settle;
    logic [1:0]       r_col;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_cap;
    logic [15:0]      r_stable;
    logic [DB_W-1:0]  r_cnt [16];
    logic [4:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_settle_done;
    logic             w_proc;
    logic [1:0]       w_row;
    logic [3:0]       w_key;
    logic             w_sample;
    logic             w_cur;
    logic [DB_W-1:0]  w_cnt_inc;
    logic             w_flip;
    logic             w_pop;
    logic             w_full;
    logic             w_accept;
    logic [CNT_W-1:0] w_count_next;

    assign w_settle_done = (r_settle == SET_W'(SETTLE_CYCLES - 1));
    assign w_proc        = (r_state >= S_PROC0) && (r_state <= S_PROC3);
    assign w_row         = 2'(r_state - S_PROC0);
    assign w_key         = {w_row, r_col};
    assign w_sample      = r_cap[w_row];
    assign w_cur         = r_stable[w_key];
    assign w_cnt_inc     = r_cnt[w_key] + DB_W'(1);
    assign w_flip        = w_proc && (w_sample != w_cur) && (w_cnt_inc == DB_W'(DEBOUNCE_SCANS));

    assign w_pop        = ev_valid & ev_ready;
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_accept     = w_flip & (~w_full | w_pop);
    assign w_count_next = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);

    assign {ev_press, ev_code} = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_DRIVE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_DRIVE:   if (w_settle_done) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_PROC0;
            S_PROC0:   w_state_next = S_PROC1;
            S_PROC1:   w_state_next = S_PROC2;
            S_PROC2:   w_state_next = S_PROC3;
            S_PROC3:   w_state_next = S_NEXT;
            default:   w_state_next = S_DRIVE;
        endcase
    end

    // Row synchronizer, settle timer, column capture and rotation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 4'b1111;
            r_sync2  <= 4'b1111;
            r_settle <= '0;
            r_col    <= '0;
            r_cap    <= '0;
            col_out  <= 4'b1110;
        end else begin
            r_sync1 <= row_in;
            r_sync2 <= r_sync1;
            case (r_state)
                S_DRIVE:   r_settle <= w_settle_done ? '0 : r_settle + SET_W'(1);
                S_CAPTURE: r_cap    <= ~r_sync2;
                S_NEXT: begin
                    col_out <= {col_out[2:0], col_out[3]};
                    r_col   <= r_col + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Shared debounce path: one key per PROC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable <= '0;
            for (int i = 0; i < 16; i++) r_cnt[i] <= '0;
        end else if (w_proc) begin
            if (w_sample == w_cur) begin
                r_cnt[w_key] <= '0;
            end else if (w_flip) begin
                r_stable[w_key] <= w_sample;
                r_cnt[w_key]    <= '0;
            end else begin
                r_cnt[w_key] <= w_cnt_inc;
            end
        end
    end

    // Event FIFO; a full push without a pop is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            ev_valid <= 1'b0;
            overflow <= 1'b0;
            key_down <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= {w_sample, w_key};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count  <= w_count_next;
            ev_valid <= (w_count_next != '0);
            overflow <= w_flip & w_full & ~w_pop;
            key_down <= |r_stable;
        end
    end

endmodule
